// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 framebuffer page-swap logic.
// The frame counter width and its saturating increment live here so the controller and bench agree.
package hub75_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FLIP    = 2'd2
    } swap_state_t;

    localparam int MIN_FRAMES_WD = 4;
    localparam int PIXEL_BPP     = 8;

    typedef logic [3*PIXEL_BPP-1:0] pixel_t;

    localparam logic [MIN_FRAMES_WD-1:0] CNT_MAX = '1;

    function automatic logic [MIN_FRAMES_WD-1:0] sat_inc(input logic [MIN_FRAMES_WD-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hub75_page_swap_ctrl_if.sv
// Host swap/write, display read and framebuffer memory signals of the page-swap controller.
// slave = controller side, master = host/display/memory side.
interface hub75_page_swap_ctrl_if #(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    parameter int bpp_p    = 8
);
    localparam int frame_size_p = hpixel_p * vpixel_p;
    localparam int addr_width_p = $clog2(frame_size_p);

    logic                    i_enable;
    logic [3:0]              i_min_frames;
    logic                    i_swap_req;
    logic                    o_swap_busy;
    logic                    o_swap_ack;
    logic                    i_frame_done;
    logic                    i_wr_valid;
    logic                    o_wr_ready;
    logic [addr_width_p-1:0] i_wr_addr;
    logic [3*bpp_p-1:0]      i_wr_data;
    logic                    o_mem_wr_en;
    logic [addr_width_p:0]   o_mem_wr_addr;
    logic [3*bpp_p-1:0]      o_mem_wr_data;
    logic [addr_width_p-1:0] i_rd_addr;
    logic [addr_width_p:0]   o_mem_rd_addr;
    logic                    o_front_bank;
    logic [3:0]              o_frames_since_swap;

    modport slave (
        input  i_enable, i_min_frames, i_swap_req, i_frame_done,
        input  i_wr_valid, i_wr_addr, i_wr_data, i_rd_addr,
        output o_swap_busy, o_swap_ack, o_wr_ready,
        output o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_mem_rd_addr,
        output o_front_bank, o_frames_since_swap
    );

    modport master (
        output i_enable, i_min_frames, i_swap_req, i_frame_done,
        output i_wr_valid, i_wr_addr, i_wr_data, i_rd_addr,
        input  o_swap_busy, o_swap_ack, o_wr_ready,
        input  o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data, o_mem_rd_addr,
        input  o_front_bank, o_frames_since_swap
    );

endinterface

// File: rtl/hub75_page_swap_ctrl.sv
// Double-buffer controller: host writes land in the back page, the display reads the front page,
// and the pages only trade places on a display frame boundary so a frame is never torn.
module hub75_page_swap_ctrl
    import hub75_pkg::*;
#(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    parameter int bpp_p    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    hub75_page_swap_ctrl_if.slave  bus
);

    localparam int frame_size_p = hpixel_p * vpixel_p;
    localparam int addr_width_p = $clog2(frame_size_p);

    swap_state_t                state_q, state_d;
    logic                       front_q;
    logic [MIN_FRAMES_WD-1:0]   cnt_q;
    logic [MIN_FRAMES_WD-1:0]   cnt_next;
    logic [MIN_FRAMES_WD-1:0]   min_eff;
    logic                       ack_q;
    logic                       wr_en_q;
    logic [addr_width_p:0]      wr_addr_q;
    logic [3*bpp_p-1:0]         wr_data_q;
    logic                       swap_busy;
    logic                       wr_ready;
    logic                       flip;
    logic                       wr_fire;

    always_comb begin
        state_d   = state_q;
        swap_busy = 1'b0;
        wr_ready  = 1'b0;
        flip      = 1'b0;
        min_eff   = (bus.i_min_frames == '0) ? MIN_FRAMES_WD'(1) : bus.i_min_frames;
        cnt_next  = sat_inc(cnt_q);

        // Disabling drops any pending request silently and parks the FSM.
        if (!bus.i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_ready = ~rst;
                    if (bus.i_swap_req) state_d = PENDING;
                end
                PENDING: begin
                    swap_busy = ~rst;
                    if (bus.i_frame_done && (cnt_next >= min_eff)) state_d = FLIP;
                end
                FLIP: begin
                    swap_busy = ~rst;
                    flip      = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_fire = bus.i_wr_valid & wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            front_q   <= 1'b0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= flip;
            if (flip) front_q <= ~front_q;

            // The flip clears the count even if a frame boundary lands in the same cycle.
            if (flip)                  cnt_q <= '0;
            else if (bus.i_frame_done) cnt_q <= cnt_next;

            wr_en_q <= wr_fire;
            if (wr_fire) begin
                wr_addr_q <= {~front_q, bus.i_wr_addr};
                wr_data_q <= bus.i_wr_data;
            end
        end
    end

    assign bus.o_swap_busy         = swap_busy;
    assign bus.o_swap_ack          = ack_q;
    assign bus.o_wr_ready          = wr_ready;
    assign bus.o_mem_wr_en         = wr_en_q;
    assign bus.o_mem_wr_addr       = wr_addr_q;
    assign bus.o_mem_wr_data       = wr_data_q;
    assign bus.o_mem_rd_addr       = {front_q, bus.i_rd_addr};
    assign bus.o_front_bank        = front_q;
    assign bus.o_frames_since_swap = cnt_q;

endmodule

// File: tb/tb_hub75_page_swap_ctrl.sv
// Directed bench for the page-swap controller: expected memory writes and swap acks are queued
// as stimulus is driven and checked by negedge monitors when the controller produces them.
module tb_hub75_page_swap_ctrl;
    import hub75_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hub75_page_swap_ctrl_if bus ();

    hub75_page_swap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int ack_seen    = 0;

    logic [36:0] wr_q[$];
    logic        ack_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.i_frame_done = 1'b1;
        step();
        bus.i_frame_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.o_mem_wr_en) begin
            check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0)
                check("wr_txn", 64'({bus.o_mem_wr_addr, bus.o_mem_wr_data}), 64'(wr_q.pop_front()));
        end
        if (!rst && bus.o_swap_ack) begin
            ack_seen++;
            check("ack_expected", 64'(ack_q.size() != 0), 64'd1);
            if (ack_q.size() != 0)
                check("ack_front", 64'(bus.o_front_bank), 64'(ack_q.pop_front()));
        end
    end

    initial begin
        bus.i_enable     = 1'b1;
        bus.i_min_frames = 4'd1;
        bus.i_swap_req   = 1'b0;
        bus.i_frame_done = 1'b0;
        bus.i_wr_valid   = 1'b0;
        bus.i_wr_addr    = '0;
        bus.i_wr_data    = '0;
        bus.i_rd_addr    = 12'd7;
        rst = 1'b1;
        step(3);

        check("rst_busy",   64'(bus.o_swap_busy), 64'd0);
        check("rst_ready",  64'(bus.o_wr_ready), 64'd0);
        check("rst_front",  64'(bus.o_front_bank), 64'd0);
        check("rst_ack",    64'(bus.o_swap_ack), 64'd0);
        check("rst_wr_en",  64'(bus.o_mem_wr_en), 64'd0);
        check("rst_wr_adr", 64'(bus.o_mem_wr_addr), 64'd0);
        check("rst_wr_dat", 64'(bus.o_mem_wr_data), 64'd0);
        check("rst_cnt",    64'(bus.o_frames_since_swap), 64'd0);

        rst = 1'b0;
        #1;
        check("idle_ready", 64'(bus.o_wr_ready), 64'd1);
        check("rd_addr_b0", 64'(bus.o_mem_rd_addr), 64'h0007);

        // Plain write goes to back page 1.
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 12'd5;
        bus.i_wr_data  = pixel_t'(24'hFF0000);
        wr_q.push_back({1'b1, 12'd5, 24'hFF0000});
        step();
        bus.i_wr_valid = 1'b0;
        check("wr1_en",   64'(bus.o_mem_wr_en), 64'd1);
        check("wr1_addr", 64'(bus.o_mem_wr_addr), 64'h1005);
        step();
        check("wr1_en_drop", 64'(bus.o_mem_wr_en), 64'd0);

        // Swap with min_frames=1; a write accepted in the request cycle still completes.
        bus.i_swap_req = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 12'd9;
        bus.i_wr_data  = pixel_t'(24'h00FF00);
        wr_q.push_back({1'b1, 12'd9, 24'h00FF00});
        step();
        bus.i_swap_req = 1'b0;
        bus.i_wr_valid = 1'b0;
        check("sw1_busy",  64'(bus.o_swap_busy), 64'd1);
        check("sw1_ready", 64'(bus.o_wr_ready), 64'd0);
        check("sw1_wr",    64'(bus.o_mem_wr_addr), 64'h1009);
        step(2);
        ack_q.push_back(1'b1);
        frame();
        check("sw1_flip_busy",  64'(bus.o_swap_busy), 64'd1);
        check("sw1_flip_front", 64'(bus.o_front_bank), 64'd0);
        check("sw1_flip_cnt",   64'(bus.o_frames_since_swap), 64'd1);
        check("sw1_flip_ack",   64'(bus.o_swap_ack), 64'd0);
        step();
        check("sw1_ack",   64'(bus.o_swap_ack), 64'd1);
        check("sw1_front", 64'(bus.o_front_bank), 64'd1);
        check("sw1_cnt",   64'(bus.o_frames_since_swap), 64'd0);
        check("sw1_idle",  64'(bus.o_swap_busy), 64'd0);
        check("sw1_rdadr", 64'(bus.o_mem_rd_addr), 64'h1007);
        step();
        check("sw1_ack_pulse", 64'(bus.o_swap_ack), 64'd0);

        // min_frames=3: only the third frame boundary flips.
        bus.i_min_frames = 4'd3;
        bus.i_swap_req   = 1'b1;
        step();
        bus.i_swap_req   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2);
            check("sw3_ready_wait", 64'(bus.o_wr_ready), 64'd0);
            if (i == 2) ack_q.push_back(1'b0);
            frame();
            check("sw3_cnt",  64'(bus.o_frames_since_swap), 64'(i + 1));
            check("sw3_busy", 64'(bus.o_swap_busy), 64'd1);
            check("sw3_front_hold", 64'(bus.o_front_bank), 64'd1);
        end
        step();
        check("sw3_ack",   64'(bus.o_swap_ack), 64'd1);
        check("sw3_front", 64'(bus.o_front_bank), 64'd0);

        // Request and frame boundary together (min_frames=0 acts as 1): flip waits for the next one.
        bus.i_min_frames = 4'd0;
        bus.i_swap_req   = 1'b1;
        bus.i_frame_done = 1'b1;
        step();
        bus.i_swap_req   = 1'b0;
        bus.i_frame_done = 1'b0;
        check("same_busy", 64'(bus.o_swap_busy), 64'd1);
        check("same_cnt",  64'(bus.o_frames_since_swap), 64'd1);
        step(3);
        check("same_noflip", 64'(bus.o_front_bank), 64'd0);
        check("same_busy2",  64'(bus.o_swap_busy), 64'd1);
        bus.i_swap_req = 1'b1;
        step();
        bus.i_swap_req = 1'b0;
        check("dup_busy", 64'(bus.o_swap_busy), 64'd1);
        ack_q.push_back(1'b1);
        frame();
        step();
        check("same_front", 64'(bus.o_front_bank), 64'd1);
        step(3);
        check("ack_total3", 64'(ack_seen), 64'd3);

        // Counter saturates, and the top address goes to back page 0.
        repeat (17) frame();
        check("cnt_sat", 64'(bus.o_frames_since_swap), 64'd15);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 12'hFFF;
        bus.i_wr_data  = pixel_t'(24'h0000FF);
        wr_q.push_back({1'b0, 12'hFFF, 24'h0000FF});
        step();
        bus.i_wr_valid = 1'b0;
        check("wr_top_addr", 64'(bus.o_mem_wr_addr), 64'h0FFF);

        // Disable while pending: request dropped, front held, no ack.
        bus.i_min_frames = 4'd1;
        bus.i_swap_req   = 1'b1;
        step();
        bus.i_swap_req   = 1'b0;
        check("en_pend_busy", 64'(bus.o_swap_busy), 64'd1);
        bus.i_enable = 1'b0;
        step();
        check("dis_busy",  64'(bus.o_swap_busy), 64'd0);
        check("dis_ready", 64'(bus.o_wr_ready), 64'd0);
        check("dis_front", 64'(bus.o_front_bank), 64'd1);
        frame();
        bus.i_enable = 1'b1;
        step(2);
        check("reen_busy",  64'(bus.o_swap_busy), 64'd0);
        check("reen_ready", 64'(bus.o_wr_ready), 64'd1);
        check("reen_front", 64'(bus.o_front_bank), 64'd1);

        // Reset mid-PENDING loses the request and returns front to 0.
        bus.i_swap_req = 1'b1;
        step();
        bus.i_swap_req = 1'b0;
        check("rst2_pend", 64'(bus.o_swap_busy), 64'd1);
        rst = 1'b1;
        step();
        check("rst2_front", 64'(bus.o_front_bank), 64'd0);
        check("rst2_busy",  64'(bus.o_swap_busy), 64'd0);
        check("rst2_cnt",   64'(bus.o_frames_since_swap), 64'd0);
        check("rst2_ready", 64'(bus.o_wr_ready), 64'd0);
        rst = 1'b0;
        frame();
        step(4);
        check("rst2_idle",     64'(bus.o_swap_busy), 64'd0);
        check("ack_total_end", 64'(ack_seen), 64'd3);
        check("ack_q_drained", 64'(ack_q.size()), 64'd0);
        check("wr_q_drained",  64'(wr_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
